vga_timing_gen: RTL and testbench

- Upstream stage of the text-mode pixel generator: produces 640x480@60 Hz VGA timing from the 50 MHz system clock.
- Drives the pixel generator's x, y and bright inputs, and the board's hsync/vsync pins.
- hsync/vsync/bright are delayed through a configurable pipeline so they stay aligned with the generator's RAM->ROM->colour latency.

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_axis_ctr.sv | 63 ++++++
 rtl/vga_timing_gen.sv | 131 +++++++++++++
 tb/tb_vga_timing_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA timing generator and the
// text-mode pixel generator downstream of it.
//   - 640x480@60 Hz horizontal/vertical timing and derived indices
//   - phase_t: the four phases each timing axis walks through
//   - text grid geometry (80x60 cells of 8x8 pixels)
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int H_SYNC_START = H_ACTIVE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int V_SYNC_START = V_ACTIVE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int COLS  = 80;
    localparam int ROWS  = 60;
    localparam int GLYPH = 8;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

endpackage

// File: rtl/vga_axis_ctr.sv
// vga_axis_ctr: one timing axis (horizontal or vertical). A wrapping counter
// 0..TOTAL-1 plus the ACTIVE/FRONT/SYNC/BACK phase FSM tracking it.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   advance      step the counter by one this clk
//   count        current position on the axis
//   phase        current phase (phase_t encoding)
//   wrap         advance while count = TOTAL-1 (counter returns to 0 next)
module vga_axis_ctr
    import vga_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FRONT  = 16,
    parameter int SYNC   = 96,
    parameter int BACK   = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       phase,
    output logic             wrap
);

    localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] FRONT_IDX = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_IDX  = CNT_W'(ACTIVE + FRONT);
    localparam logic [CNT_W-1:0] BACK_IDX  = CNT_W'(ACTIVE + FRONT + SYNC);

    phase_t           phase_q;
    phase_t           phase_d;
    logic [CNT_W-1:0] count_d;

    // The phase is decided from the value the counter is about to take, so
    // phase and count always change on the same edge.
    always_comb begin
        count_d = (count == LAST) ? '0 : count + CNT_W'(1);
        phase_d = phase_q;
        if (count_d == '0)
            phase_d = PH_ACTIVE;
        else if (count_d == BACK_IDX)
            phase_d = PH_BACK;
        else if (count_d == SYNC_IDX)
            phase_d = PH_SYNC;
        else if (count_d == FRONT_IDX)
            phase_d = PH_FRONT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= '0;
            phase_q <= PH_ACTIVE;
        end else if (advance) begin
            count   <= count_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;
    assign wrap  = advance && (count == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz VGA timing from the 50 MHz system clock.
// Ports:
//   clk          system clock, everything on posedge
//   rst_n        synchronous active-low reset
//   pix_en       one-clk pixel tick every CLK_DIV clks
//   x, y         active-region column/row, 0 while blanking
//   bright       active-video flag, SYNC_DELAY ticks behind x/y
//   hsync, vsync active-low syncs, SYNC_DELAY ticks behind x/y
//   line_start   one-clk pulse on the tick that wraps hcount to 0
//   frame_start  one-clk pulse on the tick that wraps both counters to 0
// bright/hsync/vsync lag x/y so they line up with the pixel generator's
// RAM->ROM->colour latency.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int H_FRONT    = vga_pkg::H_FRONT,
    parameter int H_SYNC     = vga_pkg::H_SYNC,
    parameter int H_BACK     = vga_pkg::H_BACK,
    parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int V_FRONT    = vga_pkg::V_FRONT,
    parameter int V_SYNC     = vga_pkg::V_SYNC,
    parameter int V_BACK     = vga_pkg::V_BACK,
    parameter int CLK_DIV    = 2,
    parameter int SYNC_DELAY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       bright,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    // {bright, hsync, vsync} while blanked: dark, syncs released
    localparam logic [2:0] BLANK = 3'b011;

    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic [1:0]       h_phase;
    logic [1:0]       v_phase;
    logic             h_wrap;
    logic             v_wrap;
    logic [2:0]       raw;
    logic [2:0]       dly;

    // Pixel tick divider; with CLK_DIV=1 div is stuck at 0 and pix_en at 1.
    always_ff @(posedge clk) begin
        if (!rst_n)
            div <= '0;
        else if (div == DIV_LAST)
            div <= '0;
        else
            div <= div + DIV_W'(1);
    end

    assign pix_en = (div == DIV_LAST);

    vga_axis_ctr #(
        .ACTIVE(H_ACTIVE),
        .FRONT (H_FRONT),
        .SYNC  (H_SYNC),
        .BACK  (H_BACK)
    ) u_h (
        .clk    (clk),
        .rst_n  (rst_n),
        .advance(pix_en),
        .count  (hcount),
        .phase  (h_phase),
        .wrap   (h_wrap)
    );

    // h_wrap already carries pix_en, so the vertical axis steps once per line.
    vga_axis_ctr #(
        .ACTIVE(V_ACTIVE),
        .FRONT (V_FRONT),
        .SYNC  (V_SYNC),
        .BACK  (V_BACK)
    ) u_v (
        .clk    (clk),
        .rst_n  (rst_n),
        .advance(h_wrap),
        .count  (vcount),
        .phase  (v_phase),
        .wrap   (v_wrap)
    );

    assign x = (h_phase == PH_ACTIVE) ? hcount : '0;
    assign y = (v_phase == PH_ACTIVE) ? vcount : '0;

    assign line_start  = h_wrap;
    assign frame_start = v_wrap;

    assign raw = {(h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE),
                  (h_phase != PH_SYNC),
                  (v_phase != PH_SYNC)};

    generate
        if (SYNC_DELAY == 0) begin : g_no_dly
            assign dly = raw;
        end else begin : g_dly
            logic [2:0] dly_p [SYNC_DELAY];

            // Stage boundary: one pixel tick per entry, dly_p[0] nearest raw.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_DELAY; i++)
                        dly_p[i] <= BLANK;
                end else if (pix_en) begin
                    dly_p[0] <= raw;
                    for (int i = 1; i < SYNC_DELAY; i++)
                        dly_p[i] <= dly_p[i-1];
                end
            end

            assign dly = dly_p[SYNC_DELAY-1];
        end
    endgenerate

    assign bright = dly[2];
    assign hsync  = dly[1];
    assign vsync  = dly[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    logic clk;
    logic rst_n;
    logic rst_s_n;

    int tests;
    int failed;

    // A: defaults (CLK_DIV=2, SYNC_DELAY=2)
    logic       pe_a, br_a, hs_a, vs_a, ls_a, fs_a;
    logic [9:0] x_a, y_a;
    // B: CLK_DIV=2, SYNC_DELAY=0
    logic       pe_b, br_b, hs_b, vs_b, ls_b, fs_b;
    logic [9:0] x_b, y_b;
    // C: CLK_DIV=1, SYNC_DELAY=0
    logic       pe_c, br_c, hs_c, vs_c, ls_c, fs_c;
    logic [9:0] x_c, y_c;
    // S: reduced geometry 25x19, CLK_DIV=2, SYNC_DELAY=1
    logic       pe_s, br_s, hs_s, vs_s, ls_s, fs_s;
    logic [9:0] x_s, y_s;

    vga_timing_gen u_a (
        .clk(clk), .rst_n(rst_n), .pix_en(pe_a), .x(x_a), .y(y_a),
        .bright(br_a), .hsync(hs_a), .vsync(vs_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(.CLK_DIV(2), .SYNC_DELAY(0)) u_b (
        .clk(clk), .rst_n(rst_n), .pix_en(pe_b), .x(x_b), .y(y_b),
        .bright(br_b), .hsync(hs_b), .vsync(vs_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    vga_timing_gen #(.CLK_DIV(1), .SYNC_DELAY(0)) u_c (
        .clk(clk), .rst_n(rst_n), .pix_en(pe_c), .x(x_c), .y(y_c),
        .bright(br_c), .hsync(hs_c), .vsync(vs_c),
        .line_start(ls_c), .frame_start(fs_c)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_ACTIVE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .CLK_DIV(2), .SYNC_DELAY(1)
    ) u_s (
        .clk(clk), .rst_n(rst_s_n), .pix_en(pe_s), .x(x_s), .y(y_s),
        .bright(br_s), .hsync(hs_s), .vsync(vs_s),
        .line_start(ls_s), .frame_start(fs_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int tk_a, tk_b, tk_c;
        int br_first_a, hs_first_a;
        int br_cnt_b, hs_cnt_b, hs_first_b, ls1_b, ls2_b, ls_n_b, fs_n_b, xmax_b;
        int br_cnt_c, hs_first_c, ls1_c, ls2_c, pe_low_c;
        int tk_s, br_cnt_s, vs_cnt_s, vs_first_s, fs1_s, fs2_s, fs_n_s, ls_n_s, ymax_s, ls_at_fs;
        int ls1_s;

        tests = 0;
        failed = 0;
        rst_n = 1'b0;
        rst_s_n = 1'b0;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_x", x_a, 0);
        check("rst_y", y_a, 0);
        check("rst_hsync", hs_a, 1);
        check("rst_vsync", vs_a, 1);
        check("rst_bright", br_a, 0);
        check("rst_pix_en", pe_a, 0);
        check("rst_line_start", ls_a, 0);
        check("rst_frame_start", fs_a, 0);
        check("div1_pix_en_rst", pe_c, 1);

        // release all full-size instances and watch 3400 clks
        rst_n = 1'b1;
        tk_a = 0; tk_b = 0; tk_c = 0;
        br_first_a = -1; hs_first_a = -1;
        br_cnt_b = 0; hs_cnt_b = 0; hs_first_b = -1; ls1_b = -1; ls2_b = -1;
        ls_n_b = 0; fs_n_b = 0; xmax_b = 0;
        br_cnt_c = 0; hs_first_c = -1; ls1_c = -1; ls2_c = -1; pe_low_c = 0;
        for (int c = 0; c < 3400; c++) begin
            if (c == 1) begin
                check("first_pix_en", pe_a, 1);
                check("x_before_tick", x_a, 0);
            end
            if (c == 2) check("x_after_tick", x_a, 1);
            if (pe_a) begin
                if (br_a && br_first_a < 0) br_first_a = tk_a;
                if (!hs_a && hs_first_a < 0) hs_first_a = tk_a;
                tk_a++;
            end
            if (pe_b) begin
                if (tk_b < 800) begin
                    if (br_b) br_cnt_b++;
                    if (!hs_b) begin
                        hs_cnt_b++;
                        if (hs_first_b < 0) hs_first_b = tk_b;
                    end
                end
                tk_b++;
            end
            if (int'(x_b) > xmax_b) xmax_b = int'(x_b);
            if (ls_b) begin
                ls_n_b++;
                if (ls1_b < 0) ls1_b = c;
                else if (ls2_b < 0) ls2_b = c;
            end
            if (fs_b) fs_n_b++;
            if (!pe_c) pe_low_c++;
            if (pe_c) begin
                if (tk_c < 800) begin
                    if (br_c) br_cnt_c++;
                    if (!hs_c && hs_first_c < 0) hs_first_c = tk_c;
                end
                tk_c++;
            end
            if (ls_c) begin
                if (ls1_c < 0) ls1_c = c;
                else if (ls2_c < 0) ls2_c = c;
            end
            @(negedge clk);
        end

        check("d2_bright_first_tick", br_first_a, 2);
        check("d2_hsync_first_tick", hs_first_a, 658);
        check("d0_bright_ticks", br_cnt_b, 640);
        check("d0_hsync_first_tick", hs_first_b, 656);
        check("d0_hsync_ticks", hs_cnt_b, 96);
        check("d0_line_start_first", ls1_b, 1599);
        check("d0_line_period", ls2_b - ls1_b, 1600);
        check("d0_line_start_clks", ls_n_b, 2);
        check("d0_frame_start_none", fs_n_b, 0);
        check("d0_x_max", xmax_b, 639);
        check("div1_pix_en_low", pe_low_c, 0);
        check("div1_line_period", ls2_c - ls1_c, 800);
        check("div1_hsync_first_tick", hs_first_c, 656);
        check("div1_bright_ticks", br_cnt_c, 640);

        // reduced geometry: full frames
        rst_s_n = 1'b0;
        @(negedge clk);
        rst_s_n = 1'b1;
        tk_s = 0; br_cnt_s = 0; vs_cnt_s = 0; vs_first_s = -1;
        fs1_s = -1; fs2_s = -1; fs_n_s = 0; ls_n_s = 0; ymax_s = 0; ls_at_fs = -1;
        for (int c = 0; c < 1950; c++) begin
            if (pe_s) begin
                if (tk_s < 475) begin
                    if (br_s) br_cnt_s++;
                    if (!vs_s) begin
                        vs_cnt_s++;
                        if (vs_first_s < 0) vs_first_s = tk_s;
                    end
                end
                tk_s++;
            end
            if (int'(y_s) > ymax_s) ymax_s = int'(y_s);
            if (ls_s) ls_n_s++;
            if (fs_s) begin
                fs_n_s++;
                if (fs1_s < 0) begin
                    fs1_s = c;
                    ls_at_fs = int'(ls_s);
                end else if (fs2_s < 0) fs2_s = c;
            end
            @(negedge clk);
        end

        check("s_bright_ticks", br_cnt_s, 192);
        check("s_vsync_first_tick", vs_first_s, 351);
        check("s_vsync_ticks", vs_cnt_s, 50);
        check("s_frame_start_first", fs1_s, 949);
        check("s_frame_period", fs2_s - fs1_s, 950);
        check("s_frame_start_clks", fs_n_s, 2);
        check("s_line_with_frame", ls_at_fs, 1);
        check("s_line_start_clks", ls_n_s, 39);
        check("s_y_max", ymax_s, 11);

        // reduced geometry: reset in the middle of a frame (hcount=20, vcount=7)
        rst_s_n = 1'b0;
        @(negedge clk);
        rst_s_n = 1'b1;
        repeat (390) @(negedge clk);
        check("s_mid_y_before_rst", y_s, 7);
        rst_s_n = 1'b0;
        @(negedge clk);
        check("s_mid_rst_x", x_s, 0);
        check("s_mid_rst_y", y_s, 0);
        check("s_mid_rst_bright", br_s, 0);
        check("s_mid_rst_hsync", hs_s, 1);
        check("s_mid_rst_vsync", vs_s, 1);
        check("s_mid_rst_pix_en", pe_s, 0);
        check("s_mid_rst_line_start", ls_s, 0);
        check("s_mid_rst_frame_start", fs_s, 0);
        rst_s_n = 1'b1;
        fs1_s = -1; fs_n_s = 0; ls1_s = -1;
        for (int c = 0; c < 1000; c++) begin
            if (ls_s && ls1_s < 0) ls1_s = c;
            if (fs_s) begin
                fs_n_s++;
                if (fs1_s < 0) fs1_s = c;
            end
            @(negedge clk);
        end
        check("s_mid_line_start_first", ls1_s, 49);
        check("s_mid_frame_start_first", fs1_s, 949);
        check("s_mid_frame_start_count", fs_n_s, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
